// File: rtl/barrel_left_seq.sv
// Multi-cycle 16-bit logical left shifter: one power-of-two stage (1, 2, 4, 8) per clock.
// Optional BARREL_LEFT_ROTATE_EN adds a rot input that turns active stages into rotates.
module barrel_left_seq #(
    parameter int WIDTH = 16,  // fixed at 16: four stages are hard-wired
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef BARREL_LEFT_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shft,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Wrap-around bits for each stage; all-zero when rotate is absent or not selected.
    logic             fill1;
    logic [1:0]       fill2;
    logic [3:0]       fill4;
    logic [7:0]       fill8;

`ifdef BARREL_LEFT_ROTATE_EN
    logic rot_q, rot_d;

    always_comb begin
        fill1 = rot_q ? acc_q[15]    : 1'b0;
        fill2 = rot_q ? acc_q[15:14] : 2'b0;
        fill4 = rot_q ? acc_q[15:12] : 4'b0;
        fill8 = rot_q ? acc_q[15:8]  : 8'b0;
    end
`else
    always_comb begin
        fill1 = 1'b0;
        fill2 = 2'b0;
        fill4 = 4'b0;
        fill8 = 8'b0;
    end
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        carry_d = carry_q;
        out_d   = out_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BARREL_LEFT_ROTATE_EN
        rot_d   = rot_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = in;
                    amt_d   = shft;
                    carry_d = 1'b0;
`ifdef BARREL_LEFT_ROTATE_EN
                    rot_d   = rot;
`endif
                    busy_d  = 1'b1;
                    state_d = S0;
                end else begin
                    state_d = IDLE;
                end
            end
            S0: begin
                if (amt_q[0]) begin
                    acc_d   = {acc_q[14:0], fill1};
                    carry_d = acc_q[15];
                end
                state_d = S1;
            end
            S1: begin
                if (amt_q[1]) begin
                    acc_d   = {acc_q[13:0], fill2};
                    carry_d = acc_q[14];
                end
                state_d = S2;
            end
            S2: begin
                if (amt_q[2]) begin
                    acc_d   = {acc_q[11:0], fill4};
                    carry_d = acc_q[12];
                end
                state_d = S3;
            end
            S3: begin
                // Final stage result goes straight to the output registers.
                out_d  = acc_q;
                cout_d = carry_q;
                if (amt_q[3]) begin
                    acc_d   = {acc_q[7:0], fill8};
                    carry_d = acc_q[8];
                    out_d   = {acc_q[7:0], fill8};
                    cout_d  = acc_q[8];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            amt_q   <= '0;
            carry_q <= 1'b0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BARREL_LEFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            carry_q <= carry_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BARREL_LEFT_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_barrel_left_seq.sv
// Scoreboard bench for barrel_left_seq: directed ops push expected results, a monitor checks on done.
module tb_barrel_left_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rot;
    logic [15:0] in;
    logic [3:0]  shft;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        cout;

    typedef struct {
        logic [15:0] out;
        logic        cout;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] last_out = 16'h0000;

    barrel_left_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef BARREL_LEFT_ROTATE_EN
        .rot   (rot),
`endif
        .in    (in),
        .shft  (shft),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .cout  (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse; also checks out is held while busy.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out", {16'h0, out}, {16'h0, e.out});
                    check("cout", {31'h0, cout}, {31'h0, e.cout});
                    check("latency", cyc, e.cyc);
                    last_out = e.out;
                end
            end else if (busy) begin
                check("out_held", {16'h0, out}, {16'h0, last_out});
            end
        end else begin
            last_out = 16'h0000;
        end
    end

    // Caller is at a negedge; start is sampled by the next posedge (E0), done expected 4 edges later.
    task automatic launch(input logic [15:0] d, input logic [3:0] s, input logic r,
                          input logic [15:0] eo, input logic ec, input bit push);
        exp_t e;
        start = 1'b1;
        in    = d;
        shft  = s;
        rot   = r;
        if (push) begin
            e.out  = eo;
            e.cout = ec;
            e.cyc  = cyc + 5;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        in    = 16'h0000;
        shft  = 4'h0;
        rot   = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] d, input logic [3:0] s, input logic r,
                          input logic [15:0] eo, input logic ec);
        @(negedge clk);
        launch(d, s, r, eo, ec, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("busy_high", {31'h0, busy}, 32'd1);
            @(negedge clk);
        end
        check("busy_low", {31'h0, busy}, 32'd0);
        check("done_high", {31'h0, done}, 32'd1);
        @(negedge clk);
        check("done_pulse", {31'h0, done}, 32'd0);
        check("pending", sb.size(), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        rot   = 1'b0;
        in    = 16'h0000;
        shft  = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_out", {16'h0, out}, 32'h0000);
        check("rst_cout", {31'h0, cout}, 32'd0);

        // Abort in S1: no done, out stays cleared.
        launch(16'h0001, 4'd4, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("abort_out", {16'h0, out}, 32'h0000);
        check("abort_cout", {31'h0, cout}, 32'd0);

        run_op(16'h0001, 4'd4,  1'b0, 16'h0010, 1'b0);
        run_op(16'h8001, 4'd1,  1'b0, 16'h0002, 1'b1);
        run_op(16'hABCD, 4'd15, 1'b0, 16'h8000, 1'b0);
        run_op(16'hFFFF, 4'd0,  1'b0, 16'hFFFF, 1'b0);
        run_op(16'h1234, 4'd8,  1'b0, 16'h3400, 1'b0);
        run_op(16'h4000, 4'd2,  1'b0, 16'h0000, 1'b1);

        // Op A, ignored start during S2, then op B accepted in A's DONE cycle.
        @(negedge clk);
        launch(16'h00F0, 4'd4, 1'b0, 16'h0F00, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        in    = 16'hFFFF;
        shft  = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("a_done", {31'h0, done}, 32'd1);
        check("a_out", {16'h0, out}, 32'h0F00);
        launch(16'h0003, 4'd2, 1'b0, 16'h000C, 1'b0, 1'b1);
        check("b_busy", {31'h0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        check("b_pending", sb.size(), 32'd0);
        check("b_out", {16'h0, out}, 32'h000C);

`ifdef BARREL_LEFT_ROTATE_EN
        run_op(16'h8001, 4'd1, 1'b1, 16'h0003, 1'b1);
        run_op(16'h1234, 4'd8, 1'b1, 16'h3412, 1'b0);
        run_op(16'h8001, 4'd1, 1'b0, 16'h0002, 1'b1);
`endif

        repeat (3) @(negedge clk);
        check("final_pending", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so a stuck DUT still reaches a summary line.
    initial begin
        #100000;
        check("timeout", 32'd1, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
